block_main_memory: RTL

//  Clocked, parametrised backing store for the cache hierarchy. Accepts one read or block-write

---
 rtl/block_main_memory.sv | 137 +++++++++++++
 1 files changed

// File: rtl/block_main_memory.sv
// block_main_memory: fixed-latency, block-organised backing store behind a valid/ready request port.
// Define MEM_WRITE_EN to enable block writes; otherwise every request is treated as a read.
module block_main_memory #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BLK_WORDS = 4,
    parameter int unsigned LATENCY   = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W*BLK_WORDS-1:0] req_wblock,
    output logic                        resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic [DATA_W*BLK_WORDS-1:0] resp_block
);
    localparam int unsigned OffW  = $clog2(BLK_WORDS);
    localparam int unsigned BlkW  = ADDR_W - OffW;
    localparam int unsigned CntW  = $clog2(LATENCY) + 1;
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);
`ifdef MEM_WRITE_EN
    localparam logic WriteEn = 1'b1;
`else
    localparam logic WriteEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]           addr_q;
    logic                        write_q;
    logic [DATA_W*BLK_WORDS-1:0] wblock_q;

    logic [DATA_W-1:0] mem [Depth];

    logic                        accept;
    logic                        load;
    logic [ADDR_W-1:0]           ld_addr;
    logic                        ld_write;
    logic [DATA_W*BLK_WORDS-1:0] ld_wblock;
    logic [OffW-1:0]             ld_off;
    logic [BlkW-1:0]             ld_blk;
    logic [DATA_W*BLK_WORDS-1:0] rd_block;
    logic [DATA_W*BLK_WORDS-1:0] nx_block;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign accept     = req_valid & req_ready;

    // load marks the edge entering StResp; with LATENCY==1 that is the acceptance edge itself,
    // so the live request inputs are used instead of the latched copies.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        ld_addr   = addr_q;
        ld_write  = write_q;
        ld_wblock = wblock_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d   = StResp;
                        load      = 1'b1;
                        ld_addr   = req_addr;
                        ld_write  = req_write & WriteEn;
                        ld_wblock = req_wblock;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntInit;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ld_off = ld_addr[OffW-1:0];
    assign ld_blk = ld_addr[ADDR_W-1:OffW];

    // A write forwards its own block so the response reflects the freshly stored data.
    always_comb begin
        rd_block = '0;
        for (int k = 0; k < BLK_WORDS; k++) begin
            rd_block[k*DATA_W +: DATA_W] = mem[{ld_blk, OffW'(k)}];
        end
        nx_block = ld_write ? ld_wblock : rd_block;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wblock_q   <= '0;
            resp_data  <= '0;
            resp_block <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= req_addr;
                write_q  <= req_write & WriteEn;
                wblock_q <= req_wblock;
            end
            if (load) begin
                resp_data  <= nx_block[ld_off*DATA_W +: DATA_W];
                resp_block <= nx_block;
            end
        end
    end

    // Array contents survive reset; a reset in the commit cycle drops the write.
    always_ff @(posedge clk) begin
        if (!rst && load && ld_write) begin
            for (int k = 0; k < BLK_WORDS; k++) begin
                mem[{ld_blk, OffW'(k)}] <= ld_wblock[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule
